serial_addsub_sched: RTL

//   Bit-serial add/subtract unit shared by the two issue lanes. One full_adder cell is

---
 rtl/serial_addsub_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_addsub_sched.sv
// rtl/serial_addsub_sched.sv - two-lane bit-serial add/subtract unit with round-robin issue
// One full_adder cell sequenced LSB first over WIDTH cycles, result on a valid/ready channel.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_addsub_sched #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [1:0]         req_sub_i,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_lane_o,
  output logic [WIDTH-1:0]   rsp_sum_o,
  output logic               rsp_cout_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             lane;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             grant_lane;
  logic             grant;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Ready is only ever raised for a lane that is valid, so ready alone marks the handshake.
  always_comb begin
    state_nxt   = state;
    req_ready_o = 2'b00;
    case (state)
      IDLE: begin
        case (req_valid_i)
          2'b01:   req_ready_o = 2'b01;
          2'b10:   req_ready_o = 2'b10;
          2'b11:   req_ready_o = last_grant ? 2'b01 : 2'b10;
          default: req_ready_o = 2'b00;
        endcase
        if (|req_ready_o) state_nxt = RUN;
      end
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant      = (state == IDLE) && (|req_ready_o);
  assign grant_lane = req_ready_o[1];
  assign sel_a      = grant_lane ? req_a_i[WIDTH +: WIDTH] : req_a_i[0 +: WIDTH];
  assign sel_b      = grant_lane ? req_b_i[WIDTH +: WIDTH] : req_b_i[0 +: WIDTH];
  assign sel_sub    = req_sub_i[grant_lane];

  // Subtraction is a + ~b + 1: invert B at latch time and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lane       <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        a_sh       <= sel_a;
        b_sh       <= sel_b ^ {WIDTH{sel_sub}};
        carry      <= sel_sub;
        lane       <= grant_lane;
        last_grant <= grant_lane;
        cnt        <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {fa_s, res_sh[WIDTH-1:1]};
        carry  <= fa_co;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state != IDLE);
  assign rsp_lane_o  = lane;
  assign rsp_sum_o   = res_sh;
  assign rsp_cout_o  = carry;
endmodule
